// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM state type and level constants for pwm_capture.
package pwm_capture_pkg;
  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;
  localparam int AVG_DEPTH = 4;
endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: 2-FF pin synchroniser with registered rise/fall strobes, held off until the pipeline holds real samples.
module pwm_capture_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  logic [2:0] primed;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      primed <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
      primed <= {primed[1:0], 1'b1};
      rise <= primed[2] & s2 & ~s3;
      fall <= primed[2] & ~s2 & s3;
    end
  end
  assign sync = s2;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers a 4-bit speed level from PWM high time per validated period; define PWM_CAPTURE_AVG_EN to report a 4-deep rounded moving average.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int STEP_CYCLES    = 6250,
  parameter int PERIOD_MIN     = 90000,
  parameter int PERIOD_MAX     = 110000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               period_err,
  output logic               signal_lost
);
  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES);
  state_t state, next;
  logic sync, rise, fall, tmo, start, eval, accept, step_wrap;
  logic [PW-1:0] period_cnt;
  logic [SW-1:0] step_cnt;
  logic [LEVEL_W-1:0] hi_level, new_level;
  pwm_capture_sync u_sync (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .sync(sync),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    tmo = state != WAIT_RISE && period_cnt == PW'(TIMEOUT_CYCLES);
    start = rise && !tmo && state != HIGH;
    eval = start && state == LOW;
    accept = eval && period_cnt >= PW'(PERIOD_MIN) && period_cnt <= PW'(PERIOD_MAX);
    step_wrap = step_cnt == SW'(STEP_CYCLES - 1);
    next = tmo ? WAIT_RISE : start ? HIGH : (state == HIGH && fall) ? LOW : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_RISE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      step_cnt <= '0;
      hi_level <= '0;
    end else if (start) begin
      period_cnt <= PW'(1);
      step_cnt <= '0;
      hi_level <= '0;
    end else begin
      if (period_cnt != PW'(TIMEOUT_CYCLES)) period_cnt <= period_cnt + 1'b1;
      if (state == HIGH) begin
        step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
        if (step_wrap && hi_level != LEVEL_MAX) hi_level <= hi_level + 1'b1;
      end
    end
  end
`ifdef PWM_CAPTURE_AVG_EN
  localparam int AW = LEVEL_W + $clog2(AVG_DEPTH);
  logic [LEVEL_W-1:0] hist [AVG_DEPTH-1];
  logic [AW-1:0] sum;
  always_comb begin
    sum = AW'(hi_level) + AW'(AVG_DEPTH / 2);
    for (int i = 0; i < AVG_DEPTH - 1; i++) sum = sum + AW'(hist[i]);
  end
  assign new_level = LEVEL_W'(sum >> $clog2(AVG_DEPTH));
  always_ff @(posedge clk) begin
    if (rst || tmo) begin
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[0] <= hi_level;
      for (int i = 1; i < AVG_DEPTH - 1; i++) hist[i] <= hist[i-1];
    end
  end
`else
  assign new_level = hi_level;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      level_valid <= 1'b0;
      period_err <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      level_valid <= accept;
      period_err <= eval && !accept;
      if (tmo) begin
        signal_lost <= 1'b1;
        level <= sync ? LEVEL_MAX : '0;
      end else if (accept) begin
        signal_lost <= 1'b0;
        level <= new_level;
      end
    end
  end
endmodule
